// File: rtl/sym9_pattern_gen.sv
// Enumerates, in ascending order, every W-bit vector whose popcount lies in [LO,HI]
// and streams them over a valid/ready handshake with progress reporting.
module sym9_pattern_gen #(
  parameter int W  = 9,
  parameter int LO = 3,
  parameter int HI = 6,
  parameter int CW = W + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [W-1:0]  pattern,
  output logic          pattern_valid,
  input  logic          pattern_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pattern_count
);

  localparam int PCW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   cand;
  logic [PCW-1:0] pc;
  logic           in_range;
  logic           cand_last;

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < W; i++) begin
      pc = pc + PCW'(cand[i]);
    end
  end

  assign in_range  = (int'(pc) >= LO) && (int'(pc) <= HI);
  // All-ones is the terminal candidate; cand is never allowed to wrap.
  assign cand_last = &cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cand          <= '0;
      pattern       <= '0;
      pattern_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pattern_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cand          <= '0;
            pattern_count <= '0;
            done          <= 1'b0;
            busy          <= 1'b1;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (in_range) begin
            pattern       <= cand;
            pattern_valid <= 1'b1;
            state         <= HOLD;
          end else if (cand_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cand <= cand + W'(1);
          end
        end
        HOLD: begin
          if (pattern_ready) begin
            pattern_valid <= 1'b0;
            pattern_count <= pattern_count + CW'(1);
            if (cand_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cand  <= cand + W'(1);
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sym9_pattern_gen.sv
// Scoreboard bench for sym9_pattern_gen: default window plus LO=0/HI=9 and LO=HI=9 instances.
module tb_sym9_pattern_gen;

  logic clk;
  logic rst;
  logic start_v [3];
  logic ready_v [3];

  logic [8:0] p0, p1, p2;
  logic       v0, v1, v2;
  logic       b0, b1, b2;
  logic       d0, d1, d2;
  logic [9:0] c0, c1, c2;

  int         sel;
  logic [8:0] cur_pat;
  logic       cur_val, cur_busy, cur_done;
  logic [9:0] cur_cnt;

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sym9_pattern_gen #(.W(9), .LO(3), .HI(6)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .pattern(p0), .pattern_valid(v0),
    .pattern_ready(ready_v[0]), .busy(b0), .done(d0), .pattern_count(c0)
  );
  sym9_pattern_gen #(.W(9), .LO(0), .HI(9)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .pattern(p1), .pattern_valid(v1),
    .pattern_ready(ready_v[1]), .busy(b1), .done(d1), .pattern_count(c1)
  );
  sym9_pattern_gen #(.W(9), .LO(9), .HI(9)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .pattern(p2), .pattern_valid(v2),
    .pattern_ready(ready_v[2]), .busy(b2), .done(d2), .pattern_count(c2)
  );

  always_comb begin
    cur_pat  = p0;
    cur_val  = v0;
    cur_busy = b0;
    cur_done = d0;
    cur_cnt  = c0;
    case (sel)
      1: begin cur_pat = p1; cur_val = v1; cur_busy = b1; cur_done = d1; cur_cnt = c1; end
      2: begin cur_pat = p2; cur_val = v2; cur_busy = b2; cur_done = d2; cur_cnt = c2; end
      default: ;
    endcase
  end

  function automatic int lo_of(input int s);
    return (s == 0) ? 3 : (s == 1) ? 0 : 9;
  endfunction

  function automatic int hi_of(input int s);
    return (s == 0) ? 6 : 9;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pattern"}, 32'(cur_pat), 0);
    chk({tag, "_valid"}, 32'(cur_val), 0);
    chk({tag, "_busy"}, 32'(cur_busy), 0);
    chk({tag, "_done"}, 32'(cur_done), 0);
    chk({tag, "_count"}, 32'(cur_cnt), 0);
  endtask

  // Loads the expected sequence for instance s and pulses start for one edge.
  task automatic start_run(input int s);
    sel = s;
    exp_q.delete();
    for (int v = 0; v < 512; v++) begin
      if ($countones(9'(v)) >= lo_of(s) && $countones(9'(v)) <= hi_of(s)) exp_q.push_back(9'(v));
    end
    @(negedge clk);
    start_v[s] = 1'b1;
    ready_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  task automatic run(input int s, input bit bp, input bit spam, input int abort_at,
                     output int first_cyc, output logic [8:0] last, output int acc);
    int cyc;
    int held;
    int pc;
    bit have_last;
    bit bp_done;
    logic [8:0] e;
    cyc = 0; held = 0; have_last = 0; bp_done = 0;
    first_cyc = -1; last = '0; acc = 0;
    while (1) begin
      chk("count", 32'(cur_cnt), 32'(acc));
      chk("busy_done_excl", 32'(cur_busy & cur_done), 0);
      chk("valid_only_busy", 32'(cur_val & ~cur_busy), 0);
      if (cur_done) break;
      if (cyc >= 5000) begin
        chk("timeout_done", 32'(cur_done), 1);
        break;
      end
      if (abort_at >= 0 && acc == abort_at) break;
      if (spam) start_v[s] = cyc[0];
      if (cur_val && first_cyc < 0) first_cyc = cyc;
      if (bp && !bp_done && cur_val && cur_pat == 9'h00B) begin
        ready_v[s] = 1'b0;
        held = acc;
        repeat (5) begin
          @(negedge clk);
          cyc++;
          chk("bp_valid", 32'(cur_val), 1);
          chk("bp_pattern", 32'(cur_pat), 32'h00B);
          chk("bp_count", 32'(cur_cnt), 32'(held));
        end
        ready_v[s] = 1'b1;
        bp_done = 1;
      end
      if (cur_val && ready_v[s]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pattern", 32'(cur_val), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pattern", 32'(cur_pat), 32'(e));
        end
        pc = $countones(cur_pat);
        chk("popcount_range", 32'(pc >= lo_of(s) && pc <= hi_of(s)), 1);
        if (have_last) chk("increasing", 32'(cur_pat > last), 1);
        last = cur_pat;
        have_last = 1;
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    start_v[s] = 1'b0;
  endtask

  task automatic end_checks(input int total, input logic [8:0] exp_last, input int exp_first,
                            input int first_cyc, input logic [8:0] last);
    chk("end_done", 32'(cur_done), 1);
    chk("end_busy", 32'(cur_busy), 0);
    chk("end_count", 32'(cur_cnt), 32'(total));
    chk("end_last", 32'(last), 32'(exp_last));
    chk("end_pattern_reg", 32'(cur_pat), 32'(exp_last));
    chk("end_valid", 32'(cur_val), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("first_valid_cycle", 32'(first_cyc), 32'(exp_first));
  endtask

  initial begin
    int fc;
    int acc;
    int ef;
    logic [8:0] last;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      ready_v[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 chk_zero("reset_held");
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 chk_zero("reset_released");
    end

    // Default window: first pattern latency and full 420-pattern sweep.
    start_run(0);
    ef = int'(exp_q[0]) + 1;
    run(0, 0, 0, -1, fc, last, acc);
    end_checks(420, 9'h1F8, ef, fc, last);

    // Restart from DONE with backpressure at 0x00B and start spammed while busy.
    start_run(0);
    run(0, 1, 1, -1, fc, last, acc);
    end_checks(420, 9'h1F8, ef, fc, last);

    // Asynchronous reset mid-run at count 57.
    start_run(0);
    run(0, 0, 0, 57, fc, last, acc);
    chk("abort_count", 32'(cur_cnt), 57);
    #1 rst = 1'b1;
    #1 chk_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("after_midrun_reset");
    start_run(0);
    chk("restart_first_expected", 32'(exp_q[0]), 32'h007);
    run(0, 0, 0, -1, fc, last, acc);
    end_checks(420, 9'h1F8, ef, fc, last);

    // LO=0, HI=9: every vector, first valid one cycle after SCAN entry.
    start_run(1);
    ef = int'(exp_q[0]) + 1;
    run(1, 0, 0, -1, fc, last, acc);
    end_checks(512, 9'h1FF, ef, fc, last);

    // LO=HI=9: single all-ones pattern.
    start_run(2);
    ef = int'(exp_q[0]) + 1;
    run(2, 0, 0, -1, fc, last, acc);
    end_checks(1, 9'h1FF, ef, fc, last);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sym9_pattern_gen.md
Name: sym9_pattern_gen

Overview:
- Sequential generator for the 9-input symmetric-function (9symml) benchmark.
- The 9symml logic checks whether the count of ones among 9 inputs lies in [3,6]. This block runs the other direction: it enumerates, in ascending numeric order, every W-bit vector whose count of ones lies in [LO,HI].
- It streams those vectors over a valid/ready interface to drive exhaustive on-chip stimulus into the combinational 9symml netlist.
- It reports progress through busy, done and a count of emitted patterns.

Parameters:
- W, 9, pattern width in bits. Legal range 2..16.
- LO, 3, minimum popcount accepted (inclusive). Requires 0 <= LO <= HI.
- HI, 6, maximum popcount accepted (inclusive). Requires HI <= W.
- CW, W+1, width of pattern_count; must hold 2^W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a new enumeration. Sampled only in IDLE or DONE.
- pattern  out  W  current in-range vector. Registered; stable while pattern_valid=1.
- pattern_valid  out  1  pattern holds an unconsumed in-range vector.
- pattern_ready  in  1  consumer accepts pattern when pattern_valid=1 and pattern_ready=1.
- busy  out  1  high in SCAN or HOLD.
- done  out  1  high in DONE, i.e. the enumeration is complete.
- pattern_count  out  CW  number of patterns accepted since the last start.

Behaviour:
- Reset (async assert, clears immediately):
  - state=IDLE, cand=0.
  - pattern=0, pattern_valid=0, busy=0, done=0, pattern_count=0.
- Internal state: candidate register cand (W bits) and a popcount of cand (combinational, ceil(log2(W+1)) bits, no truncation). in_range = (LO <= popcount(cand) <= HI).
- IDLE / DONE:
  - If start=1: cand<=0, pattern_count<=0, done<=0, go to SCAN.
  - Otherwise hold. DONE keeps done=1 and the final pattern_count.
- SCAN (one candidate per cycle):
  - in_range=1: pattern<=cand, pattern_valid<=1, go to HOLD.
  - in_range=0 and cand=2^W-1: go to DONE.
  - Otherwise: cand<=cand+1.
- HOLD:
  - pattern_valid=1; pattern and cand frozen until pattern_ready=1.
  - On handshake: pattern_valid<=0, pattern_count<=pattern_count+1.
    - If cand=2^W-1: go to DONE.
    - Else: cand<=cand+1, go to SCAN.
- Wrap-around: cand never wraps. The all-ones candidate is the terminal case in both SCAN and HOLD.
- Latency:
  - First SCAN cycle follows the edge that samples start.
  - An in-range candidate evaluated in SCAN raises pattern_valid on the next edge.
  - Each accepted pattern costs at least 2 cycles (HOLD, then SCAN).
- start while busy=1 is ignored; no restart and no glitch on outputs.
- pattern_ready while pattern_valid=0 has no effect.
- Ordering: emitted patterns are strictly increasing, with no duplicates and no omissions.
- Total patterns emitted = sum over k=LO..HI of C(W,k). Defaults give 84+126+126+84 = 420.
- Reset mid-run: all state returns to reset values immediately. A new start is required.
- done and busy are never both 1. pattern_valid=1 only in HOLD.

Test Plan:
- Reset with start=0 -> all outputs 0 and state idle. Hold rst high for 3 cycles, release -> outputs remain 0.
- Defaults, start pulse at edge E0, pattern_ready=1 -> pattern_valid first high after edge E8 with pattern=0x007 (candidates 0..7 scanned). pattern_count=1 after the handshake.
- Defaults, free-running ready=1 -> exactly 420 patterns, all strictly increasing, each popcount in 3..6. Last pattern=0x1F8. done=1 afterwards, pattern_count=420, busy=0.
- Backpressure: ready=0 for 5 cycles while pattern=0x00B -> valid stays 1, pattern stays 0x00B, count unchanged. Ready=1 -> count increments once and the next pattern is 0x00D.
- Start asserted repeatedly during busy -> no effect, sequence identical to the reference model. Rst asserted mid-run at count=57 -> immediate zeros. Restart -> first pattern 0x007 again.
- Parameters LO=0, HI=9 -> 512 patterns from 0x000 to 0x1FF, first valid 1 cycle after the SCAN entry. LO=HI=9 -> single pattern 0x1FF, then done with count=1.
